pulse_stretcher_multi: RTL and testbench
========================================

Name: pulse_stretcher_multi

Overview:
- Multi-channel, parametrised pulse stretcher. Each channel turns a short trigger on its input into an output pulse of programmable length.
- Adds three features per channel:
  - selectable edge or level triggering;
  - optional retrigger, which extends the pulse while it is high;
  - a hold-off window after each pulse, during which new triggers are ignored and flagged as dropped.
- Sits between fast single-cycle event strobes (ROM access, bus hits) and slow consumers such as LED drivers and status logic.

Parameters:
- CHANNELS, 4: number of independent channels.
- CNT_W, 4: width of the length counter and of the `stretch_len` input.
- RETRIGGER, 1: 1 = a trigger during STRETCH reloads the counter; 0 = the trigger is ignored and flagged as dropped.
- EDGE_TRIG, 1: 1 = trigger on a rising edge of `sig_in[i]`; 0 = trigger on any cycle where `sig_in[i]` is high.
- HOLDOFF, 0: number of cycles in the HOLDOFF state after STRETCH ends; 0 = HOLDOFF is skipped.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global enable; low forces every channel to IDLE.
- `sig_in`  in  CHANNELS  trigger inputs, already synchronous to `clk`.
- `stretch_len`  in  CNT_W  length code L, shared by all channels, sampled at each trigger.
- `ext_out`  out  CHANNELS  stretched outputs, registered.
- `busy`  out  CHANNELS  high when the channel is in STRETCH or HOLDOFF.
- `dropped`  out  CHANNELS  one-cycle strobe when a trigger is ignored.

Behaviour:
- One clock. Reset is asynchronous and active-high: `clk` and `reset` as above.
- Reset values:
  - `ext_out`, `busy`, `dropped` = 0;
  - all channel states = IDLE;
  - counters = 0;
  - edge-history registers = 0.
- Reset asserted mid-pulse clears everything immediately (asynchronous). No pulse completes after reset.
- Trigger definition, channel i:
  - EDGE_TRIG=1: trig = `sig_in[i]` & ~prev[i]. prev[i] updates every cycle, including when `enable` = 0.
  - Because prev resets to 0, an input already high on the first cycle after reset release counts as a rising edge.
  - EDGE_TRIG=0: trig = `sig_in[i]`.
- Per-channel FSM, states IDLE, STRETCH, HOLDOFF:
  - IDLE + trig: go to STRETCH, cnt <= `stretch_len`, `ext_out[i]` <= 1.
  - STRETCH, cnt != 0: cnt <= cnt - 1.
  - STRETCH, cnt == 0: `ext_out[i]` <= 0; go to HOLDOFF with hcnt <= HOLDOFF-1 if HOLDOFF > 0, else go to IDLE.
  - STRETCH + trig with RETRIGGER=1: cnt <= `stretch_len`, stay in STRETCH, no `dropped`. This takes priority over the cnt == 0 exit in the same cycle.
  - STRETCH + trig with RETRIGGER=0: trigger ignored, `dropped[i]` = 1 for one cycle.
  - HOLDOFF: hcnt counts down. At hcnt == 0 go to IDLE. Any trig while in HOLDOFF raises `dropped[i]` and is otherwise ignored.
- Timing:
  - Latency: trig sampled at edge k, so `ext_out` is high from edge k.
  - Pulse width is exactly L+1 cycles. L=0 gives 1 cycle; L=2^CNT_W-1 gives 2^CNT_W cycles.
  - Retrigger at the m-th high cycle gives total width m+L+1 cycles.
  - A trigger in the same cycle as the HOLDOFF→IDLE transition is dropped. Triggers are accepted only in IDLE.
- `stretch_len` changes affect only subsequent triggers and reloads. The value latched at the trigger edge governs the pulse.
- `busy[i]` = (state != IDLE), registered alongside the state.
- `enable` = 0:
  - next edge forces all states to IDLE;
  - `ext_out`, `busy`, `dropped` go to 0;
  - no triggers are accepted.
- Channels are fully independent; simultaneous triggers on all channels are all serviced.
- Counter arithmetic is CNT_W bits wide. Wrap below 0 is impossible because the cnt == 0 exit is checked first.
- The HOLDOFF counter width is $clog2(HOLDOFF+1), minimum 1.

Test Plan:
1. Defaults, L=15, single 1-cycle pulse on `sig_in[0]` -> `ext_out[0]` high exactly 16 cycles starting the edge after the trigger; other channels stay 0.
2. L=3, RETRIGGER=1, second trigger on the 3rd high cycle -> width 3+3+1 = 7 cycles; `dropped` stays 0.
3. RETRIGGER=0, L=3, second trigger mid-pulse -> width 4 cycles; `dropped[0]` high for 1 cycle aligned to the second trigger.
4. HOLDOFF=5, L=0: trigger, then a trigger 3 cycles after the pulse falls -> second trigger dropped, `busy` high for 1+5 cycles; a trigger 6 cycles after the fall produces a new pulse.
5. EDGE_TRIG=1, `sig_in[1]` held high 40 cycles, L=7 -> exactly one 8-cycle pulse. EDGE_TRIG=0, same stimulus -> continuous retriggering, `ext_out[1]` high for 40+7 cycles.
6. Assert `reset` asynchronously mid-pulse, and separately drop `enable` mid-pulse -> `ext_out`/`busy` go to 0 immediately (reset) or at the next edge (enable); no residual pulse after release.

Source files
------------

// File: rtl/pulse_stretcher_multi.sv
// Multi-channel pulse stretcher: each channel turns a trigger into a registered pulse of
// stretch_len+1 cycles, with optional retrigger and a post-pulse hold-off window.
module pulse_stretcher_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned RETRIGGER = 1,
  parameter int unsigned EDGE_TRIG = 1,
  parameter int unsigned HOLDOFF   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic [CNT_W-1:0]    stretch_len,
  output logic [CHANNELS-1:0] ext_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] dropped
);

  localparam int unsigned HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned HLOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [1:0] {StIdle, StStretch, StHoldoff} state_e;

  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] trig;

  // Edge history keeps tracking the input even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= sig_in;
    end
  end

  assign trig = (EDGE_TRIG != 0) ? (sig_in & ~prev_q) : sig_in;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             ext_q, ext_d;
    logic             busy_q;
    logic             drop_q, drop_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        ext_q   <= 1'b0;
        busy_q  <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        ext_q   <= ext_d;
        busy_q  <= (state_d != StIdle);
        drop_q  <= drop_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      ext_d   = ext_q;
      drop_d  = 1'b0;
      if (!enable) begin
        state_d = StIdle;
        cnt_d   = '0;
        hcnt_d  = '0;
        ext_d   = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (trig[i]) begin
              state_d = StStretch;
              cnt_d   = stretch_len;
              ext_d   = 1'b1;
            end
          end
          StStretch: begin
            // A reload wins over the terminal-count exit in the same cycle.
            if (trig[i] && (RETRIGGER != 0)) begin
              cnt_d = stretch_len;
            end else begin
              drop_d = trig[i];
              if (cnt_q == '0) begin
                ext_d = 1'b0;
                if (HOLDOFF > 0) begin
                  state_d = StHoldoff;
                  hcnt_d  = HW'(HLOAD);
                end else begin
                  state_d = StIdle;
                end
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
          StHoldoff: begin
            drop_d = trig[i];
            if (hcnt_q == '0) begin
              state_d = StIdle;
            end else begin
              hcnt_d = hcnt_q - HW'(1);
            end
          end
          default: begin
            state_d = StIdle;
            ext_d   = 1'b0;
          end
        endcase
      end
    end

    assign ext_out[i] = ext_q;
    assign busy[i]    = busy_q;
    assign dropped[i] = drop_q;
  end

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Bench for pulse_stretcher_multi: four parameter variants share one stimulus stream and are
// compared every cycle against a pulse-timeline model.
module tb_pulse_stretcher_multi;

  // Variants: 0 default, 1 no retrigger, 2 hold-off 5, 3 level trigger.
  localparam int CFG_RETRIG [4] = '{1, 0, 1, 1};
  localparam int CFG_HOLD   [4] = '{0, 0, 5, 0};
  localparam int CFG_EDGE   [4] = '{1, 1, 1, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] sig_in;
  logic [3:0] stretch_len;
  logic [3:0] ext_o  [4];
  logic [3:0] busy_o [4];
  logic [3:0] drp_o  [4];

  logic [15:0] got_ext, got_busy, got_drp;
  logic [15:0] exp_ext, exp_busy, exp_drp;

  int total = 0;
  int bad   = 0;

  // Model: per variant/channel, the last edge index at which the output is high.
  int         last_hi [4][4];
  logic [3:0] prev_m;
  int         t = 0;

  always #5 clk = ~clk;

  pulse_stretcher_multi #(.CHANNELS(4), .CNT_W(4), .RETRIGGER(1), .EDGE_TRIG(1), .HOLDOFF(0))
    u_def (.clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
           .stretch_len(stretch_len), .ext_out(ext_o[0]), .busy(busy_o[0]), .dropped(drp_o[0]));
  pulse_stretcher_multi #(.CHANNELS(4), .CNT_W(4), .RETRIGGER(0), .EDGE_TRIG(1), .HOLDOFF(0))
    u_nrt (.clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
           .stretch_len(stretch_len), .ext_out(ext_o[1]), .busy(busy_o[1]), .dropped(drp_o[1]));
  pulse_stretcher_multi #(.CHANNELS(4), .CNT_W(4), .RETRIGGER(1), .EDGE_TRIG(1), .HOLDOFF(5))
    u_ho (.clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
          .stretch_len(stretch_len), .ext_out(ext_o[2]), .busy(busy_o[2]), .dropped(drp_o[2]));
  pulse_stretcher_multi #(.CHANNELS(4), .CNT_W(4), .RETRIGGER(1), .EDGE_TRIG(0), .HOLDOFF(0))
    u_lvl (.clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
           .stretch_len(stretch_len), .ext_out(ext_o[3]), .busy(busy_o[3]), .dropped(drp_o[3]));

  assign got_ext  = {ext_o[3], ext_o[2], ext_o[1], ext_o[0]};
  assign got_busy = {busy_o[3], busy_o[2], busy_o[1], busy_o[0]};
  assign got_drp  = {drp_o[3], drp_o[2], drp_o[1], drp_o[0]};

  task automatic model_reset();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) last_hi[c][i] = -1000;
    prev_m   = '0;
    exp_ext  = '0;
    exp_busy = '0;
    exp_drp  = '0;
  endtask

  // Predicts the outputs after the coming edge, then advances to just past that edge.
  task automatic step();
    t++;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        logic tr, d, idle, stretching;
        tr = (CFG_EDGE[c] != 0) ? (sig_in[i] & ~prev_m[i]) : sig_in[i];
        d  = 1'b0;
        idle       = t > last_hi[c][i] + CFG_HOLD[c] + 1;
        stretching = !idle && (t <= last_hi[c][i] + 1);
        if (!enable) begin
          last_hi[c][i] = -1000;
        end else if (tr) begin
          if (idle || (stretching && CFG_RETRIG[c] != 0)) last_hi[c][i] = t + int'(stretch_len);
          else d = 1'b1;
        end
        exp_ext[c*4+i]  = (t <= last_hi[c][i]);
        exp_busy[c*4+i] = (t <= last_hi[c][i] + CFG_HOLD[c]);
        exp_drp[c*4+i]  = d;
      end
    end
    prev_m = sig_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sig_in = '0; stretch_len = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({got_ext, got_busy, got_drp} !== 48'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {got_ext, got_busy, got_drp});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_pulse();
    int w, oth;
    w = 0; oth = 0;
    stretch_len = 4'd15;
    for (int k = 0; k < 30; k++) begin
      sig_in = (k == 0) ? 4'b0001 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL single_pulse k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      w += int'(got_ext[0]);
      oth += int'(got_ext[3:1] != 3'b000);
    end
    total++;
    if (w != 16) begin bad++; $display("FAIL single_pulse_width got=%0d want=16", w); end
    total++;
    if (oth != 0) begin bad++; $display("FAIL single_pulse_others got=%0d want=0", oth); end
  endtask

  task automatic test_retrigger();
    int w_def, d_def, w_nrt, d_nrt, d_idx;
    w_def = 0; d_def = 0; w_nrt = 0; d_nrt = 0; d_idx = -1;
    stretch_len = 4'd3;
    for (int k = 0; k < 20; k++) begin
      sig_in = (k == 0 || k == 3) ? 4'b0001 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL retrigger k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      w_def += int'(got_ext[0]);
      d_def += int'(got_drp[0]);
      w_nrt += int'(got_ext[4]);
      d_nrt += int'(got_drp[4]);
      if (got_drp[4]) d_idx = k;
    end
    total++;
    if (w_def != 7) begin bad++; $display("FAIL retrig_width got=%0d want=7", w_def); end
    total++;
    if (d_def != 0) begin bad++; $display("FAIL retrig_dropped got=%0d want=0", d_def); end
    total++;
    if (w_nrt != 4) begin bad++; $display("FAIL noretrig_width got=%0d want=4", w_nrt); end
    total++;
    if (d_nrt != 1 || d_idx != 3) begin
      bad++;
      $display("FAIL noretrig_dropped got=%0d@%0d want=1@3", d_nrt, d_idx);
    end
  endtask

  task automatic test_holdoff();
    int b;
    logic drp4, ext7;
    b = 0; drp4 = 1'b0; ext7 = 1'b0;
    stretch_len = 4'd0;
    for (int k = 0; k < 25; k++) begin
      sig_in = (k == 0 || k == 4 || k == 7) ? 4'b0001 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL holdoff k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      if (k <= 6) b += int'(got_busy[8]);
      if (k == 4) drp4 = got_drp[8];
      if (k == 7) ext7 = got_ext[8];
    end
    total++;
    if (b != 6) begin bad++; $display("FAIL holdoff_busy got=%0d want=6", b); end
    total++;
    if (drp4 !== 1'b1) begin bad++; $display("FAIL holdoff_drop got=%b want=1", drp4); end
    total++;
    if (ext7 !== 1'b1) begin bad++; $display("FAIL holdoff_repulse got=%b want=1", ext7); end
  endtask

  task automatic test_level();
    int w_edge, w_lvl;
    w_edge = 0; w_lvl = 0;
    stretch_len = 4'd7;
    for (int k = 0; k < 70; k++) begin
      sig_in = (k < 40) ? 4'b0010 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL level k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      w_edge += int'(got_ext[1]);
      w_lvl  += int'(got_ext[13]);
    end
    total++;
    if (w_edge != 8) begin bad++; $display("FAIL edge_hold_width got=%0d want=8", w_edge); end
    total++;
    if (w_lvl != 47) begin bad++; $display("FAIL level_hold_width got=%0d want=47", w_lvl); end
  endtask

  task automatic test_all_channels();
    logic [15:0] first;
    stretch_len = 4'd2;
    first = '0;
    for (int k = 0; k < 15; k++) begin
      sig_in = (k == 0) ? 4'b1111 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL all_channels k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      if (k == 0) first = got_ext;
    end
    total++;
    if (first !== 16'hffff) begin bad++; $display("FAIL all_channels_start got=%h want=ffff", first); end
  endtask

  task automatic test_enable();
    int w;
    logic [15:0] at_off;
    w = 0; at_off = 'x;
    stretch_len = 4'd15;
    for (int k = 0; k < 30; k++) begin
      sig_in = (k == 0) ? 4'b0001 : 4'b0000;
      enable = (k != 4);
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL enable k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      w += int'(got_ext[0]);
      if (k == 4) at_off = got_ext | got_busy;
    end
    enable = 1'b1;
    total++;
    if (at_off !== 16'h0) begin bad++; $display("FAIL enable_off got=%h want=0", at_off); end
    total++;
    if (w != 4) begin bad++; $display("FAIL enable_width got=%0d want=4", w); end
  endtask

  task automatic test_async_reset();
    int w;
    logic first2;
    w = 0; first2 = 1'b0;
    stretch_len = 4'd15;
    sig_in = 4'b0001;
    step();
    sig_in = 4'b0000;
    repeat (3) step();
    #2;
    reset  = 1'b1;
    sig_in = 4'b0100;
    #1;
    total++;
    if ({got_ext, got_busy, got_drp} !== 48'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {got_ext, got_busy, got_drp});
    end
    model_reset();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      sig_in = (k < 3) ? 4'b0100 : 4'b0000;
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
      w += int'(got_ext[0]);
      if (k == 0) first2 = got_ext[2];
    end
    total++;
    if (w != 0) begin bad++; $display("FAIL residual_pulse got=%0d want=0", w); end
    total++;
    if (first2 !== 1'b1) begin bad++; $display("FAIL high_at_release got=%b want=1", first2); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      sig_in = 4'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) stretch_len = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 24) != 0);
      step();
      total++;
      if ({got_ext, got_busy, got_drp} !== {exp_ext, exp_busy, exp_drp}) begin
        bad++;
        $display("FAIL random k=%0d got=%h want=%h", k,
                 {got_ext, got_busy, got_drp}, {exp_ext, exp_busy, exp_drp});
      end
    end
    enable = 1'b1;
    sig_in = '0;
    repeat (25) step();
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_holdoff();
    test_level();
    test_all_channels();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
